// File: rtl/timing_meter.sv
// timing_meter
//   Measures the raster timing and peak active luma of a pixel stream.
//   All inputs are qualified by ce_pix. Horizontal results are latched at
//   every line start (HSync falling), vertical results and peak luma at every
//   frame start (VSync rising). The first frame start after reset or timeout
//   only arms the measurement.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   ce_pix         : pixel enable, qualifies every input below
//   HBlank, VBlank : active-high blanking
//   HSync          : active-low horizontal sync
//   VSync          : active-high vertical sync
//   video          : 8-bit luma sample
//   h_total, h_active, hs_width : last complete line (samples)
//   v_total, v_active, vs_width : last complete frame (line starts)
//   peak_luma      : max active luma of the last complete frame
//   frame_count    : frame starts seen since reset (wraps)
//   new_frame      : one-clk pulse when frame results update
//   valid          : results present and no timeout since
//   stable         : last two latched timing tuples were identical
module timing_meter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        HBlank,
  input  logic        HSync,
  input  logic        VBlank,
  input  logic        VSync,
  input  logic [7:0]  video,
  output logic [9:0]  h_total,
  output logic [9:0]  h_active,
  output logic [9:0]  hs_width,
  output logic [9:0]  v_total,
  output logic [9:0]  v_active,
  output logic [9:0]  vs_width,
  output logic [7:0]  peak_luma,
  output logic [15:0] frame_count,
  output logic        new_frame,
  output logic        valid,
  output logic        stable
);

  localparam logic [9:0] CNT_MAX = 10'd1023;

  logic        hs_prev_reg, vs_prev_reg;
  logic [9:0]  h_cnt_reg, ha_cnt_reg, hsw_cnt_reg;
  logic [9:0]  v_cnt_reg, va_cnt_reg, vsw_cnt_reg;
  logic [7:0]  peak_reg;
  logic        line_armed_reg, frame_armed_reg, ref_valid_reg;
  logic [59:0] ref_tuple_reg;

  logic        line_start, frame_start, qual, timeout;
  logic        line_latch, frame_latch;
  logic [9:0]  h_cnt_next, ha_cnt_next, hsw_cnt_next;
  logic [9:0]  v_cnt_next, va_cnt_next, vsw_cnt_next;
  logic [9:0]  h_total_next, h_active_next, hs_width_next;
  logic [7:0]  peak_next;
  logic [59:0] tuple_new;

  function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic en);
    sat_inc = (en && (v != CNT_MAX)) ? v + 10'd1 : v;
  endfunction

  always_comb begin
    line_start  = ce_pix & hs_prev_reg & ~HSync;
    frame_start = ce_pix & ~vs_prev_reg & VSync;
    qual        = ~HBlank & ~VBlank;

    // A line start restarts the pixel counters with the current sample counted.
    h_cnt_next   = line_start ? 10'd1 : sat_inc(h_cnt_reg, 1'b1);
    ha_cnt_next  = line_start ? {9'd0, ~HBlank} : sat_inc(ha_cnt_reg, ~HBlank);
    hsw_cnt_next = line_start ? 10'd1 : sat_inc(hsw_cnt_reg, ~HSync);

    // A line start coincident with a frame start becomes line 1 of the new frame.
    if (frame_start) begin
      v_cnt_next   = {9'd0, line_start};
      va_cnt_next  = {9'd0, line_start & ~VBlank};
      vsw_cnt_next = {9'd0, line_start & VSync};
    end else begin
      v_cnt_next   = sat_inc(v_cnt_reg, line_start);
      va_cnt_next  = sat_inc(va_cnt_reg, line_start & ~VBlank);
      vsw_cnt_next = sat_inc(vsw_cnt_reg, line_start & VSync);
    end

    // Fires on every sample that leaves a counter at its ceiling, so a stuck
    // sync keeps the meter disarmed until activity resumes.
    timeout = ce_pix & ((h_cnt_next == CNT_MAX) | (v_cnt_next == CNT_MAX));

    line_latch  = line_start & line_armed_reg & ~timeout;
    frame_latch = frame_start & frame_armed_reg & ~timeout;

    h_total_next  = line_latch ? h_cnt_reg   : h_total;
    h_active_next = line_latch ? ha_cnt_reg  : h_active;
    hs_width_next = line_latch ? hsw_cnt_reg : hs_width;

    // Stability compares the values the outputs will show after this edge,
    // so a coincident line latch is already included.
    tuple_new = {h_total_next, h_active_next, hs_width_next,
                 v_cnt_reg, va_cnt_reg, vsw_cnt_reg};

    if (frame_start) begin
      peak_next = qual ? video : 8'd0;
    end else if (qual && (video > peak_reg)) begin
      peak_next = video;
    end else begin
      peak_next = peak_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev_reg     <= 1'b1;
      vs_prev_reg     <= 1'b0;
      h_cnt_reg       <= '0;
      ha_cnt_reg      <= '0;
      hsw_cnt_reg     <= '0;
      v_cnt_reg       <= '0;
      va_cnt_reg      <= '0;
      vsw_cnt_reg     <= '0;
      peak_reg        <= '0;
      line_armed_reg  <= 1'b0;
      frame_armed_reg <= 1'b0;
      ref_valid_reg   <= 1'b0;
      ref_tuple_reg   <= '0;
      h_total         <= '0;
      h_active        <= '0;
      hs_width        <= '0;
      v_total         <= '0;
      v_active        <= '0;
      vs_width        <= '0;
      peak_luma       <= '0;
      frame_count     <= '0;
      new_frame       <= 1'b0;
      valid           <= 1'b0;
      stable          <= 1'b0;
    end else begin
      new_frame <= frame_latch;
      if (ce_pix) begin
        hs_prev_reg <= HSync;
        vs_prev_reg <= VSync;
        h_cnt_reg   <= h_cnt_next;
        ha_cnt_reg  <= ha_cnt_next;
        hsw_cnt_reg <= hsw_cnt_next;
        v_cnt_reg   <= v_cnt_next;
        va_cnt_reg  <= va_cnt_next;
        vsw_cnt_reg <= vsw_cnt_next;
        peak_reg    <= peak_next;
        h_total     <= h_total_next;
        h_active    <= h_active_next;
        hs_width    <= hs_width_next;
        if (frame_start) begin
          frame_count <= frame_count + 16'd1;
        end
        if (timeout) begin
          line_armed_reg  <= 1'b0;
          frame_armed_reg <= 1'b0;
          ref_valid_reg   <= 1'b0;
          valid           <= 1'b0;
          stable          <= 1'b0;
        end else begin
          if (line_start) begin
            line_armed_reg <= 1'b1;
          end
          if (frame_start) begin
            frame_armed_reg <= 1'b1;
          end
          if (frame_latch) begin
            v_total       <= v_cnt_reg;
            v_active      <= va_cnt_reg;
            vs_width      <= vsw_cnt_reg;
            peak_luma     <= peak_reg;
            valid         <= 1'b1;
            stable        <= ref_valid_reg && (tuple_new == ref_tuple_reg);
            ref_tuple_reg <= tuple_new;
            ref_valid_reg <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timing_meter.sv
// Testbench for timing_meter: directed raster frames driven through a
// sample-level model built on queues of recorded samples and lines.
module tb_timing_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic        HBlank = 1'b1, HSync = 1'b1, VBlank = 1'b1, VSync = 1'b0;
  logic [7:0]  video = 8'd0;
  logic [9:0]  h_total, h_active, hs_width, v_total, v_active, vs_width;
  logic [7:0]  peak_luma;
  logic [15:0] frame_count;
  logic        new_frame, valid, stable;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  timing_meter dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
    .video(video),
    .h_total(h_total), .h_active(h_active), .hs_width(hs_width),
    .v_total(v_total), .v_active(v_active), .vs_width(vs_width),
    .peak_luma(peak_luma), .frame_count(frame_count),
    .new_frame(new_frame), .valid(valid), .stable(stable)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed { logic hb; logic hs; } pix_t;
  typedef struct packed { logic vb; logic vs; } line_t;

  pix_t       line_q[$];   // samples since the last line start
  line_t      frame_q[$];  // line starts since the last frame start
  logic [7:0] luma_q[$];   // qualifying luma since the last frame start

  logic m_hs_prev, m_vs_prev, m_line_armed, m_frame_armed, m_ref_ok;
  int   m_ref[6];
  int   m_h_total, m_h_active, m_hs_width, m_v_total, m_v_active, m_vs_width, m_peak;
  logic [15:0] m_frame_count;
  logic m_new_frame, m_valid, m_stable;

  function automatic int cap(input int n);
    return (n > 1023) ? 1023 : n;
  endfunction

  function automatic void model_reset();
    line_q.delete(); frame_q.delete(); luma_q.delete();
    m_hs_prev = 1'b1; m_vs_prev = 1'b0;
    m_line_armed = 1'b0; m_frame_armed = 1'b0; m_ref_ok = 1'b0;
    for (int i = 0; i < 6; i++) m_ref[i] = 0;
    m_h_total = 0; m_h_active = 0; m_hs_width = 0;
    m_v_total = 0; m_v_active = 0; m_vs_width = 0; m_peak = 0;
    m_frame_count = 16'd0; m_new_frame = 1'b0; m_valid = 1'b0; m_stable = 1'b0;
  endfunction

  function automatic void model_sample(input logic hb, input logic hs, input logic vb,
                                       input logic vs, input logic [7:0] vid);
    bit ls, fs, tmo, same;
    int new_len, new_lines, na, nsw, nva, nvs, pk;
    int cur[6];
    ls = m_hs_prev && !hs;
    fs = !m_vs_prev && vs;
    new_len   = ls ? 1 : line_q.size() + 1;
    new_lines = (fs ? 0 : frame_q.size()) + (ls ? 1 : 0);
    tmo = (new_len >= 1023) || (new_lines >= 1023);
    m_new_frame = 1'b0;
    if (ls && m_line_armed && !tmo) begin
      na = 0; nsw = 0;
      foreach (line_q[i]) begin
        if (!line_q[i].hb) na++;
        if (!line_q[i].hs) nsw++;
      end
      m_h_total = cap(line_q.size()); m_h_active = cap(na); m_hs_width = cap(nsw);
    end
    if (fs && m_frame_armed && !tmo) begin
      nva = 0; nvs = 0; pk = 0;
      foreach (frame_q[i]) begin
        if (!frame_q[i].vb) nva++;
        if (frame_q[i].vs) nvs++;
      end
      foreach (luma_q[i]) if (int'(luma_q[i]) > pk) pk = int'(luma_q[i]);
      m_v_total = cap(frame_q.size()); m_v_active = cap(nva); m_vs_width = cap(nvs);
      m_peak = pk;
      cur[0] = m_h_total; cur[1] = m_h_active; cur[2] = m_hs_width;
      cur[3] = m_v_total; cur[4] = m_v_active; cur[5] = m_vs_width;
      same = 1'b1;
      for (int i = 0; i < 6; i++) if (cur[i] != m_ref[i]) same = 1'b0;
      m_stable = m_ref_ok && same;
      for (int i = 0; i < 6; i++) m_ref[i] = cur[i];
      m_ref_ok = 1'b1; m_valid = 1'b1; m_new_frame = 1'b1;
    end
    if (fs) m_frame_count = m_frame_count + 16'd1;
    if (tmo) begin
      m_line_armed = 1'b0; m_frame_armed = 1'b0; m_ref_ok = 1'b0;
      m_valid = 1'b0; m_stable = 1'b0;
    end else begin
      if (ls) m_line_armed = 1'b1;
      if (fs) m_frame_armed = 1'b1;
    end
    if (ls) line_q.delete();
    line_q.push_back('{hb: hb, hs: hs});
    if (fs) begin
      frame_q.delete();
      luma_q.delete();
    end
    if (ls) frame_q.push_back('{vb: vb, vs: vs});
    if (!hb && !vb) luma_q.push_back(vid);
    m_hs_prev = hs; m_vs_prev = vs;
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [86:0] act, exp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        act = {h_total, h_active, hs_width, v_total, v_active, vs_width,
               peak_luma, frame_count, new_frame, valid, stable};
        exp = {10'(m_h_total), 10'(m_h_active), 10'(m_hs_width),
               10'(m_v_total), 10'(m_v_active), 10'(m_vs_width),
               8'(m_peak), m_frame_count, m_new_frame, m_valid, m_stable};
        n_total++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act, exp);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end else begin
      $display("check %s = %0d ok", nm, act);
    end
  endtask

  // Entered and left on a negedge; one ce_pix sample then div-1 idle clocks.
  task automatic pix(input logic hb, input logic hs, input logic vb, input logic vs,
                     input logic [7:0] vid, input int div);
    ce_pix = 1'b1; HBlank = hb; HSync = hs; VBlank = vb; VSync = vs; video = vid;
    @(posedge clk);
    model_sample(hb, hs, vb, vs, vid);
    @(negedge clk);
    ce_pix = 1'b0;
    for (int i = 1; i < div; i++) begin
      @(posedge clk);
      m_new_frame = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ce_pix = 1'b1; HSync = 1'b0; VSync = 1'b1;
    HBlank = 1'b0; VBlank = 1'b0; video = 8'd255;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0; ce_pix = 1'b0; HSync = 1'b1; VSync = 1'b0;
    $display("reset applied");
  endtask

  // Sync pulses open each line/frame, so line and frame starts coincide.
  task automatic gen_frame(input int hh, input int hsw, input int ha, input int vv,
                           input int vsw, input int va, input int div, input int n_lines);
    logic hb, hs, vb, vs;
    logic [7:0] vid;
    for (int y = 0; y < n_lines; y++) begin
      vs = (y < vsw);
      vb = !((y >= 2 * vsw) && (y < 2 * vsw + va));
      for (int x = 0; x < hh; x++) begin
        hs = !(x < hsw);
        hb = !((x >= 2 * hsw) && (x < 2 * hsw + ha));
        vid = hb ? 8'd255 : (vb ? 8'd250 : 8'((x - 2 * hsw) * 200 / (ha - 1)));
        pix(hb, hs, vb, vs, vid, div);
      end
    end
    $display("frame %0dx%0d (%0d lines sent) frame_count=%0d valid=%0b stable=%0b",
             hh, vv, n_lines, frame_count, valid, stable);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_h_total", int'(h_total), 0);
    check("reset_v_total", int'(v_total), 0);
    check("reset_frame_count", int'(frame_count), 0);
    check("reset_valid", int'(valid), 0);

    // 400-wide frames, ce_pix every other clock
    gen_frame(400, 32, 320, 6, 2, 2, 2, 6);
    gen_frame(400, 32, 320, 6, 2, 2, 2, 6);
    check("a_h_total", int'(h_total), 400);
    check("a_h_active", int'(h_active), 320);
    check("a_hs_width", int'(hs_width), 32);
    check("a_v_total", int'(v_total), 6);
    check("a_v_active", int'(v_active), 2);
    check("a_vs_width", int'(vs_width), 2);
    check("a_peak_luma", int'(peak_luma), 200);
    check("a_valid", int'(valid), 1);
    check("a_stable_first", int'(stable), 0);
    gen_frame(400, 32, 320, 6, 2, 2, 2, 6);
    check("a_stable", int'(stable), 1);
    check("a_frame_count", int'(frame_count), 3);

    // 262-line frames, coincident H/V sync edges
    gen_frame(12, 2, 6, 262, 3, 240, 1, 262);
    gen_frame(12, 2, 6, 262, 3, 240, 1, 262);
    check("b_v_total", int'(v_total), 262);
    check("b_v_active", int'(v_active), 240);
    check("b_vs_width", int'(vs_width), 3);
    check("b_h_total", int'(h_total), 12);
    check("b_stable_change", int'(stable), 0);
    gen_frame(12, 2, 6, 262, 3, 240, 1, 262);
    check("b_stable", int'(stable), 1);
    gen_frame(12, 2, 6, 263, 3, 240, 1, 263);
    gen_frame(12, 2, 6, 263, 3, 240, 1, 263);
    check("b_v_total_263", int'(v_total), 263);
    check("b_stable_263_first", int'(stable), 0);
    gen_frame(12, 2, 6, 262, 3, 240, 1, 262);
    check("b_stable_263", int'(stable), 1);
    check("b_frame_count", int'(frame_count), 9);

    // HSync stuck high -> timeout
    for (int i = 0; i < 1100; i++) pix(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1);
    check("to_valid", int'(valid), 0);
    check("to_stable", int'(stable), 0);
    check("to_h_total_hold", int'(h_total), 12);
    check("to_v_total_hold", int'(v_total), 263);
    gen_frame(12, 2, 6, 262, 3, 240, 1, 262);
    check("to_rearm_valid", int'(valid), 0);
    check("to_rearm_count", int'(frame_count), 10);
    gen_frame(12, 2, 6, 262, 3, 240, 1, 262);
    check("to_recover_valid", int'(valid), 1);
    check("to_recover_v_total", int'(v_total), 262);

    // reset mid-frame
    gen_frame(12, 2, 6, 262, 3, 240, 1, 50);
    do_reset();
    @(negedge clk);
    check("mid_reset_h_total", int'(h_total), 0);
    check("mid_reset_peak", int'(peak_luma), 0);
    check("mid_reset_valid", int'(valid), 0);
    gen_frame(12, 2, 6, 262, 3, 240, 1, 262);
    check("post_reset_frame_count", int'(frame_count), 1);
    check("post_reset_valid", int'(valid), 0);
    check("post_reset_v_total", int'(v_total), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/timing_meter.md
TIMING_METER -- requirements
Module: timing_meter

Interface
REQ-001 clk  in  1  system clock; all logic on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ce_pix  in  1  pixel enable; inputs below are sampled only on clk edges with ce_pix=1.
REQ-004 HBlank  in  1  horizontal blank, active-high.
REQ-005 HSync  in  1  horizontal sync, active-low.
REQ-006 VBlank  in  1  vertical blank, active-high.
REQ-007 VSync  in  1  vertical sync, active-high.
REQ-008 video  in  8  luma sample.
REQ-009 h_total  out  10  ce_pix samples per line, last complete line.
REQ-010 h_active  out  10  HBlank=0 samples in last complete line.
REQ-011 hs_width  out  10  HSync=0 samples in last complete line.
REQ-012 v_total  out  10  line starts in last complete frame.
REQ-013 v_active  out  10  line starts with VBlank=0 in last complete frame.
REQ-014 vs_width  out  10  line starts with VSync=1 in last complete frame.
REQ-015 peak_luma  out  8  max video over HBlank=0 and VBlank=0 samples, last complete frame.
REQ-016 frame_count  out  16  count of frame starts; wraps 65535->0.
REQ-017 new_frame  out  1  one-clk pulse when frame results update.
REQ-018 valid  out  1  at least one complete frame measured and no timeout since.
REQ-019 stable  out  1  last two complete frames gave identical results.

Function
REQ-020 Edge detection SHALL compare the current sample with the previous ce_pix sample; the previous-sample registers SHALL update only when ce_pix=1.
REQ-021 Line start = HSync 1->0; frame start = VSync 0->1.
REQ-022 Pixel counters SHALL increment once per ce_pix sample and saturate at 1023.
REQ-023 On line start: h_total, h_active, hs_width SHALL latch the counts for the samples strictly before this one; counters SHALL restart counting with this sample included.
REQ-024 Line counters SHALL be updated at each line start using VBlank/VSync as sampled on that same sample; they SHALL saturate at 1023.
REQ-025 On frame start: v_total, v_active, vs_width, peak_luma SHALL latch the frame just ended; frame_count SHALL increment; new_frame SHALL pulse for exactly one clk.
REQ-026 If line start and frame start coincide on one sample, that line SHALL be excluded from the latched frame and SHALL be counted as line 1 of the new frame (v_total counts lines strictly before).
REQ-027 Peak tracker SHALL restart on frame start, including the coincident sample if it qualifies.
REQ-028 Latency: all latched outputs SHALL be visible on the clk edge after the ce_pix sample carrying the edge.
REQ-029 The first frame start after reset SHALL only arm measurement: no output latch, no new_frame, frame_count SHALL still increment.
REQ-030 valid SHALL set on the first latch of frame results.
REQ-031 stable SHALL set when a newly latched tuple (h_total, h_active, hs_width, v_total, v_active, vs_width) equals the previous frame's tuple, and SHALL clear on any mismatch; peak_luma is excluded.
REQ-032 Timeout: pixel counter reaching 1023 or line counter reaching 1023 SHALL clear valid and stable and re-arm as after reset (REQ-029); latched values SHALL hold.
REQ-033 With ce_pix=0 no state except new_frame deassertion SHALL change.

Reset
REQ-034 reset SHALL clear all outputs, counters, edge history (HSync history=1, VSync history=0), arm state and the stability reference, and SHALL win over any simultaneous ce_pix event.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; measurement SHALL restart per REQ-029.

Verification
V-1 Synthetic 400x262 frames (HSync low 32 samples, HBlank low 320, VSync 3 lines, VBlank low 240 lines, ce_pix every 4 clk) -> after frame 2: h_total=400, h_active=320, hs_width=32, v_total=262, v_active=240, vs_width=3, valid=1; after frame 3: stable=1.
V-2 HSync and VSync edges on same sample -> v_total=262 (not 263); next frame's line count starts at 1.
V-3 Frame 4 with 263 lines -> v_total=263, stable=0; frame 5 with 263 -> stable=1.
V-4 Hold HSync high for 1100 ce_pix -> valid=0, stable=0 at count 1023; outputs hold; recovers valid after two frame starts.
V-5 Active luma ramp 0..200 with 255 injected only during HBlank -> peak_luma=200.
V-6 reset mid-frame after valid=1 -> all outputs 0 next clk; first post-reset frame start gives frame_count=1, no new_frame.
